// File: rtl/multi_cycle_adder.sv
// rtl/multi_cycle_adder.sv - chunked multi-cycle add/subtract unit with valid/ready handshakes
module multi_cycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("multi_cycle_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   res;
    logic               c_next;
    logic               last;

    assign in_ready = (state == IDLE) && !rst;
    assign last     = (cnt == CW'(N - 1));

    // Select the operand slice addressed by the chunk counter, LSB chunk first.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                a_chunk = a_reg[i*CHUNK +: CHUNK];
                b_chunk = b_reg[i*CHUNK +: CHUNK];
            end
        end
        {c_next, res} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CW'(i)) begin
                            sum[i*CHUNK +: CHUNK] <= res;
                        end
                    end
                    carry <= c_next;
                    if (last) begin
                        cout      <= c_next;
                        // The top chunk result is still combinational here, so use res for the sign bit.
                        ovf       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (res[CHUNK-1] != a_reg[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// tb/tb_multi_cycle_adder.sv - self-checking bench for multi_cycle_adder
module tb_multi_cycle_adder;

    localparam int W = 16;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                         input logic msub, output logic [W-1:0] msum, output logic mcout,
                         output logic movf);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        if (!msub) begin
            ur    = ua + ub + int'(mcin);
            sr    = sa + sb + int'(mcin);
            mcout = (ur >= 65536);
        end else begin
            ur    = ua - ub - int'(mcin);
            sr    = sa - sb - int'(mcin);
            mcout = (ur >= 0);
        end
        msum = W'(ur & 32'hFFFF);
        movf = (sr > 32767) || (sr < -32768);
    endtask

    // Issue one operation, check latency and result, then consume it.
    task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic ocin, input logic osub, input logic [W-1:0] esum,
                          input logic ecout, input logic eovf);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        k = 1;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'(LAT));
        check({tag, " sum"},  32'(sum),  32'(esum));
        check({tag, " cout"}, 32'(cout), 32'(ecout));
        check({tag, " ovf"},  32'(ovf),  32'(eovf));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [W-1:0] hs;
        logic         hc, ho;
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        vecs.push_back('{16'h0007, 16'h0004, 1'b0, 1'b0, 16'h000B, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h0004, 16'h000E, 1'b0, 1'b1, 16'hFFF6, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
        vecs.push_back('{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        step();
        step();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum",       32'(sum),       32'd0);
        check("reset cout",      32'(cout),      32'd0);
        check("reset ovf",       32'(ovf),       32'd0);
        check("reset in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            if (i % 8 == 0) ra = 16'h7FFF;
            if (i % 8 == 1) ra = 16'h8000;
            model(ra, rb, rc, rs, hs, hc, ho);
            run_op($sformatf("rand%0d", i), ra, rb, rc, rs, hs, hc, ho);
        end

        // DONE held with out_ready low while new operands are offered.
        model(16'h7FFF, 16'h0001, 1'b0, 1'b0, hs, hc, ho);
        a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b1;
        for (int k = 0; k < 20 && !out_valid; k++) step();
        for (int k = 0; k < 3; k++) begin
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold sum",       32'(sum),       32'(hs));
            check("hold cout",      32'(cout),      32'(hc));
            check("hold ovf",       32'(ovf),       32'(ho));
            check("hold in_ready",  32'(in_ready),  32'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold release out_valid", 32'(out_valid), 32'd0);
        check("no extra accept", 32'(in_ready), 32'd1);
        step();
        check("no extra result", 32'(out_valid), 32'd0);

        // Abort mid-RUN after two chunks.
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort sum",       32'(sum),       32'd0);
        check("abort in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("abort in_ready after", 32'(in_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            step();
            check("abort no output", 32'(out_valid), 32'd0);
        end
        run_op("after abort", 16'h0007, 16'h0004, 1'b0, 1'b0, 16'h000B, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
